// File: rtl/event_issuer.sv
// event_issuer: sender side of the feature-detector event-input interface.
// Upstream DVS/AER events (value + {x,y} address) are queued in a small FIFO.
// Each rising edge of the detector's event_req grants one event, which is
// released as a one-cycle strobe on the out_event_*_0 bus. A minimum number
// of idle cycles (MIN_GAP) follows every strobe.
//
// Optional feature, macro EVENT_ISSUER_STATS_EN: when defined, adds saturating
// 32-bit issued_cnt / dropped_cnt outputs. When undefined, those ports and
// counters are absent and all other behaviour is identical.
module event_issuer #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_GAP    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_value,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic                          event_req,
  output logic                          out_event_valid_0,
  output logic [DATA_WIDTH-1:0]         out_event_value_0,
  output logic [ADDR_WIDTH-1:0]         out_event_addr_0,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
`ifdef EVENT_ISSUER_STATS_EN
  ,
  output logic [31:0]                   issued_cnt,
  output logic [31:0]                   dropped_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem_value [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [GW-1:0]         gap_cnt;
  logic                  req_d;
  logic                  credit;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic req_rise;

  // Full/empty are derived from the occupancy count, not from the pointers.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses input even in a pop cycle: no same-cycle refill.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign drop     = in_valid && full;
  assign req_rise = event_req && !req_d;
  assign pop      = (state == ST_IDLE) && credit && !empty;

  assign fifo_count = count;

  // FIFO storage write port.
  // NOTE: the storage array carries no reset; only pointers and count need one,
  // and leaving the array unreset lets it map onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_value[wr_ptr] <= in_value;
      mem_addr[wr_ptr]  <= in_addr;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag: set when an event is offered to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Request edge detection and single-entry credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d  <= 1'b0;
      credit <= 1'b0;
    end else begin
      req_d <= event_req;
      if (state == ST_ISSUE) begin
        // The issued event consumes the credit unless a fresh edge lands now.
        credit <= req_rise;
      end else if (req_rise) begin
        credit <= 1'b1;
      end
    end
  end

  // Issue FSM with registered strobe and held output payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      gap_cnt           <= '0;
      out_event_valid_0 <= 1'b0;
      out_event_value_0 <= '0;
      out_event_addr_0  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state             <= ST_ISSUE;
            out_event_valid_0 <= 1'b1;
            out_event_value_0 <= mem_value[rd_ptr];
            out_event_addr_0  <= mem_addr[rd_ptr];
          end
        end
        ST_ISSUE: begin
          out_event_valid_0 <= 1'b0;
          if (MIN_GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state             <= ST_IDLE;
          out_event_valid_0 <= 1'b0;
        end
      endcase
    end
  end

`ifdef EVENT_ISSUER_STATS_EN
  // Saturating statistics counters for issued strobes and dropped events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (out_event_valid_0 && (issued_cnt != 32'hFFFF_FFFF)) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (drop && (dropped_cnt != 32'hFFFF_FFFF)) begin
        dropped_cnt <= dropped_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_event_issuer.sv
// Directed testbench for event_issuer (default parameters: 4/16/16/2).
module tb_event_issuer;

  localparam int DW    = 4;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_value = '0;
  logic [AW-1:0] in_addr = '0;
  logic          event_req = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_value;
  logic [AW-1:0] out_addr;
  logic [CW-1:0] fifo_count;
  logic          overflow;
`ifdef EVENT_ISSUER_STATS_EN
  logic [31:0]   issued_cnt;
  logic [31:0]   dropped_cnt;
`endif

  event_issuer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .MIN_GAP(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_value         (in_value),
    .in_addr          (in_addr),
    .event_req        (event_req),
    .out_event_valid_0(out_valid),
    .out_event_value_0(out_value),
    .out_event_addr_0 (out_addr),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
`ifdef EVENT_ISSUER_STATS_EN
    ,
    .issued_cnt       (issued_cnt),
    .dropped_cnt      (dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    event_req = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] val;
    logic [AW-1:0] addr;
    logic          req;
    logic          e_valid;
    logic [DW-1:0] e_val;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [17];

  // Overall time guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            n;
    int            t_strobe [3];
    logic [DW-1:0] v_strobe [3];
    logic [AW-1:0] a_strobe [3];
    logic [DW-1:0] exp_val;
    logic [AW-1:0] exp_addr;
    logic [7:0]    ib;
    logic          seen;

    // ---- reset state ----
    do_reset();
    check("reset_valid", out_valid, 0);
    check("reset_value", out_value, 0);
    check("reset_addr", out_addr, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ready", in_ready, 1);
    check("reset_overflow", overflow, 0);

    // ---- basic issue, push/pop collision, credit during gap, held level ----
    //            v  val    addr      req  e_v e_val  e_addr    e_cnt
    vecs[0]  = '{1'b1, 4'hF, 16'h3030, 1'b0, 1'b0, 4'h0, 16'h0000, 5'd1};
    vecs[1]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h0, 16'h0000, 5'd1};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 4'hF, 16'h3030, 5'd0};
    vecs[3]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'hF, 16'h3030, 5'd0};
    vecs[4]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'hF, 16'h3030, 5'd0};
    vecs[5]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'hF, 16'h3030, 5'd0};
    vecs[6]  = '{1'b1, 4'h1, 16'h1111, 1'b0, 1'b0, 4'hF, 16'h3030, 5'd1};
    vecs[7]  = '{1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 4'hF, 16'h3030, 5'd2};
    vecs[8]  = '{1'b1, 4'h3, 16'h3333, 1'b1, 1'b1, 4'h1, 16'h1111, 5'd2};
    vecs[9]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h1, 16'h1111, 5'd2};
    vecs[10] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h1, 16'h1111, 5'd2};
    vecs[11] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h1, 16'h1111, 5'd2};
    vecs[12] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 4'h2, 16'h2222, 5'd1};
    vecs[13] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h2, 16'h2222, 5'd1};
    vecs[14] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h2, 16'h2222, 5'd1};
    vecs[15] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h2, 16'h2222, 5'd1};
    vecs[16] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h2, 16'h2222, 5'd1};

    for (int i = 0; i < 17; i++) begin
      in_valid  = vecs[i].v;
      in_value  = vecs[i].val;
      in_addr   = vecs[i].addr;
      event_req = vecs[i].req;
      step();
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_value", i), out_value, vecs[i].e_val);
      check($sformatf("vec%0d_addr", i), out_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_cnt);
      check($sformatf("vec%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;

    // ---- credit first, data 20 cycles later ----
    do_reset();
    event_req = 1'b1;
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) n++;
    end
    check("credit_first_no_early_strobe", n, 0);
    in_valid = 1'b1;
    in_value = 4'b1000;
    in_addr  = {8'd58, 8'd58};
    step();
    in_valid = 1'b0;
    check("credit_first_lat1_valid", out_valid, 0);
    check("credit_first_lat1_count", fifo_count, 1);
    step();
    check("credit_first_valid", out_valid, 1);
    check("credit_first_value", out_value, 4'h8);
    check("credit_first_addr", out_addr, 16'h3A3A);
    check("credit_first_count", fifo_count, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) n++;
    end
    check("credit_first_no_extra", n, 0);
    event_req = 1'b0;

    // ---- ordering and gap with a toggling request ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_value = DW'(5 + i);
      in_addr  = AW'(16'h0A01 + i * 16'h0101);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      event_req = ~event_req;
      step();
      if (out_valid) begin
        if (n < 3) begin
          t_strobe[n] = c;
          v_strobe[n] = out_value;
          a_strobe[n] = out_addr;
        end
        n++;
      end
    end
    event_req = 1'b0;
    check("order_strobe_count", n, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        check($sformatf("order%0d_value", i), v_strobe[i], 5 + i);
        check($sformatf("order%0d_addr", i), a_strobe[i], 16'h0A01 + i * 16'h0101);
      end
      if (i > 0 && i < n) begin
        check($sformatf("order%0d_spacing_ge3", i), (t_strobe[i] - t_strobe[i-1]) >= 3, 1);
      end
    end

    // ---- overflow: 17 pushes into a 16-deep FIFO, then drain ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ib       = 8'(i);
      in_valid = 1'b1;
      in_value = ib[3:0];
      in_addr  = {ib + 8'h40, ib};
      check($sformatf("ovf_ready_before_push%0d", i), in_ready, (i < 16) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    check("ovf_count_full", fifo_count, 16);
    check("ovf_ready_low", in_ready, 0);
    check("ovf_flag_set", overflow, 1);
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      event_req = ~event_req;
      step();
      if (out_valid) begin
        ib       = 8'(n);
        exp_val  = ib[3:0];
        exp_addr = {ib + 8'h40, ib};
        check($sformatf("drain%0d_value", n), out_value, exp_val);
        check($sformatf("drain%0d_addr", n), out_addr, exp_addr);
        n++;
      end
    end
    event_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) n++;
    end
    check("drain_strobe_count", n, 16);
    check("drain_count_empty", fifo_count, 0);
    check("drain_overflow_sticky", overflow, 1);
`ifdef EVENT_ISSUER_STATS_EN
    check("stats_issued", issued_cnt, 16);
    check("stats_dropped", dropped_cnt, 1);
`endif

    // ---- full FIFO in a pop cycle: no same-cycle refill ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_value = 4'h1;
      in_addr  = 16'h0101;
      step();
    end
    in_value  = 4'hE;
    in_addr   = 16'hEEEE;
    event_req = 1'b1;
    step();
    check("full_pop_credit_count", fifo_count, 16);
    step();
    check("full_pop_valid", out_valid, 1);
    check("full_pop_no_refill", fifo_count, 15);
    in_valid  = 1'b0;
    event_req = 1'b0;
    step();
    check("full_pop_count_after", fifo_count, 15);

    // ---- asynchronous reset during ISSUE ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_value = DW'(i);
      in_addr  = AW'(16'h7700 + i);
      step();
    end
    in_valid  = 1'b0;
    event_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = out_valid;
    end
    check("areset_reached_issue", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    check("areset_valid_cut", out_valid, 0);
    check("areset_count_flushed", fifo_count, 0);
    check("areset_overflow", overflow, 0);
    check("areset_ready", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) n++;
    end
    check("areset_no_strobe_while_empty", n, 0);
    in_valid = 1'b1;
    in_value = 4'h9;
    in_addr  = 16'h5A5A;
    step();
    in_valid = 1'b0;
    check("areset_push_no_strobe_yet", out_valid, 0);
    step();
    check("areset_post_valid", out_valid, 1);
    check("areset_post_value", out_value, 4'h9);
    check("areset_post_addr", out_addr, 16'h5A5A);
    step();
    check("areset_post_single", out_valid, 0);
    event_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
